mac_seq_ctrl: RTL
=================

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 Parameter DEPTH, default 8: entries filled and consumed per run, power of two, at least 2.
REQ-002 Parameter DATA_W, default 8: width of generated FIFO write data.
REQ-003 Parameter STEP_A, default 5: increment for FIFO A fill pattern.
REQ-004 Parameter STEP_B, default 10: increment for FIFO B fill pattern.
REQ-005 Parameter STALL_MAX, default 16: number of consecutive EXEC stall cycles that aborts a run.
REQ-006 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-007 Port rst, input, 1: asynchronous, active-high reset.
REQ-008 Port start, input, 1: restart request, honoured only in DONE.
REQ-009 Port fifo_a_full and fifo_b_full, input, 1 each: full flags from the two operand FIFOs.
REQ-010 Port fifo_a_empty and fifo_b_empty, input, 1 each: empty flags from the two operand FIFOs.
REQ-011 Port fill_wr_en, output, 1: write strobe to both FIFOs.
REQ-012 Port fill_data_a and fill_data_b, output, DATA_W each: write data for FIFO A and FIFO B.
REQ-013 Port rd_en, output, 1: read strobe to both FIFOs.
REQ-014 Port mac_en, output, 1: MAC accumulate enable, aligned with valid FIFO read data.
REQ-015 Port mac_clr, output, 1: one-cycle MAC accumulator clear.
REQ-016 Port state, output, 2: current state, encoded FILL=00, EXEC=01, DONE=10; 11 is never driven.
REQ-017 Port done, output, 1: high while in DONE.
REQ-018 Port err, output, 1: sticky flag for a stall abort.

Function
REQ-019 The FSM SHALL have states FILL, EXEC and DONE, and SHALL enter FILL on reset with no start required.
REQ-020 FILL write strobe: fill_wr_en = (state==FILL) & (wr_idx<DEPTH) & !fifo_a_full & !fifo_b_full; it is combinational from registered state.
REQ-021 FILL write data: fill_data_a = wr_idx*STEP_A and fill_data_b = wr_idx*STEP_B, both truncated to DATA_W; wr_idx increments on each strobe.
REQ-022 FILL exit: FILL -> EXEC when wr_idx==DEPTH & fifo_a_full & fifo_b_full.
REQ-023 FILL hold: if wr_idx==DEPTH but either full flag is low, the FSM SHALL stay in FILL with no further writes.
REQ-024 EXEC read strobe: rd_en = (state==EXEC) & (rd_idx<DEPTH) & !fifo_a_empty & !fifo_b_empty; rd_idx increments on each strobe.
REQ-025 mac_en SHALL equal rd_en registered one cycle, matching the FIFOs' one-cycle read latency (show-ahead off).
REQ-026 EXEC exit: EXEC -> DONE on the first cycle in which rd_idx==DEPTH and mac_en==1, i.e. registered, so DONE begins the cycle after the last mac_en; an unstalled EXEC lasts DEPTH+1 cycles.
REQ-027 Stall counting: a cycle in EXEC with rd_idx<DEPTH and either empty flag high SHALL increment stall_cnt; any rd_en SHALL clear stall_cnt.
REQ-028 Stall abort: stall_cnt reaching STALL_MAX SHALL set err and move to DONE with no further rd_en.
REQ-029 DONE hold: DONE SHALL hold indefinitely with done=1.
REQ-030 DONE restart: start=1 in DONE SHALL move to FILL, clear wr_idx, rd_idx, stall_cnt and err, and assert mac_clr for exactly the first FILL cycle.
REQ-031 start SHALL be ignored in FILL and in EXEC.
REQ-032 Full flags during EXEC and empty flags during FILL SHALL be ignored.
REQ-033 The FSM SHALL never assert fill_wr_en and rd_en in the same cycle.

Reset
REQ-034 Asserting rst at any time, including mid-FILL or mid-EXEC, SHALL asynchronously force: state=FILL, wr_idx=0, rd_idx=0, stall_cnt=0, err=0, mac_en=0, mac_clr=0, done=0.
REQ-035 While rst is high, fill_wr_en and rd_en SHALL be 0.
REQ-036 After rst is released, the first write SHALL occur in the first clock cycle in which both full flags are low.

Verification
REQ-037 Normal run, depth-8 FIFO models with 1-cycle read latency and a MAC model: after reset -> 8 writes with A=0,5,...,35 and B=0,10,...,70, then EXEC, then DONE; accumulator=7000 (0x1B58); state sequence 00 -> 01 -> 10.
REQ-038 Unstalled EXEC: exactly 8 rd_en cycles followed by 8 mac_en cycles, each mac_en lagging its rd_en by 1 cycle; DONE entered 9 cycles after EXEC entry.
REQ-039 Force fifo_b_empty=1 for 5 cycles mid-EXEC: rd_en held at 0 for those cycles; run resumes; result still 7000; err=0.
REQ-040 Hold fifo_a_empty=1 throughout EXEC: after 16 cycles -> DONE with err=1; zero mac_en pulses.
REQ-041 Assert rst during the 4th EXEC read: state=00 immediately, without waiting for a clock edge; after release -> full rerun with result 7000.
REQ-042 start pulses in FILL and EXEC have no effect; a start pulse in DONE gives 1 cycle of mac_clr, then a second run with result 7000 and err cleared.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mac_seq_ctrl
// Description : Sequencer for a two-operand MAC. It fills two operand FIFOs
//               with arithmetic patterns, then streams them into the MAC. A
//               run is aborted if the read side starves for too long.
//               The controller parks in DONE until it is restarted.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_seq_ctrl #(
  parameter int DEPTH     = 8,   // entries per run, power of two, >= 2
  parameter int DATA_W    = 8,   // width of generated write data
  parameter int STEP_A    = 5,   // fill pattern increment, FIFO A
  parameter int STEP_B    = 10,  // fill pattern increment, FIFO B
  parameter int STALL_MAX = 16   // consecutive starved EXEC cycles before abort
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              fifo_a_full,
  input  logic              fifo_b_full,
  input  logic              fifo_a_empty,
  input  logic              fifo_b_empty,
  output logic              fill_wr_en,
  output logic [DATA_W-1:0] fill_data_a,
  output logic [DATA_W-1:0] fill_data_b,
  output logic              rd_en,
  output logic              mac_en,
  output logic              mac_clr,
  output logic [1:0]        state,
  output logic              done,
  output logic              err
);

  // Index counters need one extra bit so they can hold DEPTH itself.
  localparam int IDX_W   = $clog2(DEPTH) + 1;
  localparam int STALL_W = $clog2(STALL_MAX + 1);

  localparam logic [1:0] ST_FILL = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic [IDX_W-1:0]   C_DEPTH      = IDX_W'(DEPTH);
  localparam logic [IDX_W-1:0]   C_IDX_ONE    = IDX_W'(1);
  localparam logic [STALL_W-1:0] C_STALL_ONE  = STALL_W'(1);
  localparam logic [STALL_W-1:0] C_STALL_LAST = STALL_W'(STALL_MAX - 1);

  logic [1:0]         state_q,     state_d;
  logic [IDX_W-1:0]   wr_idx_q,    wr_idx_d;
  logic [IDX_W-1:0]   rd_idx_q,    rd_idx_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               err_q,       err_d;
  logic               mac_en_q,    mac_en_d;
  logic               mac_clr_q,   mac_clr_d;

  logic w_in_fill;
  logic w_in_exec;
  logic w_wr_room;
  logic w_rd_left;
  logic w_wr_fire;
  logic w_rd_fire;
  logic w_stalled;

  assign w_in_fill = (state_q == ST_FILL);
  assign w_in_exec = (state_q == ST_EXEC);
  assign w_wr_room = (wr_idx_q < C_DEPTH);
  assign w_rd_left = (rd_idx_q < C_DEPTH);

  // Strobes are gated by rst so nothing reaches the FIFOs while reset is held.
  // Full flags only matter in FILL and empty flags only in EXEC, which keeps
  // the two strobes mutually exclusive by construction.
  assign w_wr_fire = !rst && w_in_fill && w_wr_room && !fifo_a_full && !fifo_b_full;
  assign w_rd_fire = !rst && w_in_exec && w_rd_left && !fifo_a_empty && !fifo_b_empty;
  assign w_stalled = w_in_exec && w_rd_left && (fifo_a_empty || fifo_b_empty);

  // Patterns are index times step, wrapped to the data width.
  assign fill_data_a = DATA_W'(wr_idx_q) * DATA_W'(STEP_A);
  assign fill_data_b = DATA_W'(wr_idx_q) * DATA_W'(STEP_B);

  assign fill_wr_en = w_wr_fire;
  assign rd_en      = w_rd_fire;
  assign mac_en     = mac_en_q;
  assign mac_clr    = mac_clr_q;
  assign state      = state_q;
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;

  // Next-state and counter update logic for the fill / execute / done sequence.
  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    stall_cnt_d = stall_cnt_q;
    err_d       = err_q;
    mac_en_d    = w_rd_fire;  // FIFO read data arrives one cycle after rd_en
    mac_clr_d   = 1'b0;

    case (state_q)
      ST_FILL: begin
        if (w_wr_fire) begin
          wr_idx_d = wr_idx_q + C_IDX_ONE;
        end else if (!w_wr_room && fifo_a_full && fifo_b_full) begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (w_rd_fire) begin
          rd_idx_d    = rd_idx_q + C_IDX_ONE;
          stall_cnt_d = '0;
        end else if (w_stalled) begin
          stall_cnt_d = stall_cnt_q + C_STALL_ONE;
        end

        // Leave only once the last read's data has been accumulated.
        if (!w_rd_left && mac_en_q) begin
          state_d = ST_DONE;
        end else if (w_stalled && (stall_cnt_q == C_STALL_LAST)) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end

      ST_DONE: begin
        if (start) begin
          state_d     = ST_FILL;
          wr_idx_d    = '0;
          rd_idx_d    = '0;
          stall_cnt_d = '0;
          err_d       = 1'b0;
          mac_clr_d   = 1'b1;
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // State registers with asynchronous reset into FILL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FILL;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_clr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
      mac_en_q    <= mac_en_d;
      mac_clr_q   <= mac_clr_d;
    end
  end

endmodule
`default_nettype wire
